// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the cpu instruction-fetch port (I_*)
// and data-access port (D_*). Requests are serialised with busywait handshakes;
// each access is followed by one IDLE cycle so the memory sees the request drop.
// Default arbitration: data first, with an instruction starvation guard.
// Optional build macro ARB_ROUND_ROBIN_EN: contention alternates between ports.
module mem_port_arbiter #(
  parameter logic [3:0] I_READ_CODE = 4'b0010,
  parameter int         STARVE_MAX  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] I_ADDR,
  input  logic        I_READ,
  output logic [31:0] I_INSTRUCTION,
  output logic        I_BUSYWAIT,
  input  logic [3:0]  D_READ,
  input  logic [2:0]  D_WRITE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WRITE_DATA,
  output logic [31:0] D_READ_DATA,
  output logic        D_BUSYWAIT,
  output logic [3:0]  MEM_READ,
  output logic [2:0]  MEM_WRITE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WRITE_DATA,
  input  logic [31:0] MEM_READ_DATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   i_req;
  logic   d_req;
  logic   grant_i;

  assign i_req = I_READ;
  assign d_req = (|D_READ) | (|D_WRITE);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_i;

  // On contention the port that was not served last wins.
  always_comb begin
    grant_i = i_req;
    if (i_req && d_req) grant_i = ~last_grant_i;
  end
`else
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0] starve_cnt;

  // On contention data wins unless fetch has been passed over STARVE_MAX times.
  always_comb begin
    grant_i = i_req;
    if (i_req && d_req) grant_i = (starve_cnt >= STARVE_LIM);
  end
`endif

  // Arbitration FSM: grant from IDLE, hold until memory completes, then back to IDLE.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_i <= 1'b1;
`else
      starve_cnt <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state <= SERVE_I;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_i <= 1'b1;
`else
            starve_cnt <= 3'd0;
`endif
          end else if (d_req) begin
            state <= SERVE_D;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_i <= 1'b0;
`else
            if (i_req && (starve_cnt != 3'd7)) starve_cnt <= starve_cnt + 3'd1;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (!MEM_BUSYWAIT) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the granted port onto the memory bus; everything is zero while idle.
  always_comb begin
    MEM_READ       = 4'd0;
    MEM_WRITE      = 3'd0;
    MEM_ADDR       = 32'd0;
    MEM_WRITE_DATA = 32'd0;
    I_INSTRUCTION  = 32'd0;
    D_READ_DATA    = 32'd0;
    case (state)
      SERVE_I: begin
        MEM_READ      = I_READ_CODE;
        MEM_ADDR      = I_ADDR;
        I_INSTRUCTION = MEM_READ_DATA;
      end
      SERVE_D: begin
        MEM_READ       = D_READ;
        MEM_WRITE      = D_WRITE;
        MEM_ADDR       = D_ADDR;
        MEM_WRITE_DATA = D_WRITE_DATA;
        D_READ_DATA    = MEM_READ_DATA;
      end
      default: ;
    endcase
  end

  // A requester is released only in the cycle its own access completes.
  assign I_BUSYWAIT = i_req & ~((state == SERVE_I) & ~MEM_BUSYWAIT);
  assign D_BUSYWAIT = d_req & ~((state == SERVE_D) & ~MEM_BUSYWAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: bench-side memory with programmable latency,
// a port-ownership model checked every cycle, and directed scenarios with
// hand-computed grant orders, spacings and captured bus values.
module tb_mem_port_arbiter;

  localparam logic [3:0] I_CODE = 4'b0010;
  localparam int         STARVE = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] I_ADDR;
  logic        I_READ;
  logic [31:0] I_INSTRUCTION;
  logic        I_BUSYWAIT;
  logic [3:0]  D_READ;
  logic [2:0]  D_WRITE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WRITE_DATA;
  logic [31:0] D_READ_DATA;
  logic        D_BUSYWAIT;
  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] MEM_READ_DATA;
  logic        MEM_BUSYWAIT;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.I_READ_CODE(I_CODE), .STARVE_MAX(STARVE)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_ADDR(I_ADDR), .I_READ(I_READ), .I_INSTRUCTION(I_INSTRUCTION), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITE_DATA(D_WRITE_DATA),
    .D_READ_DATA(D_READ_DATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_WRITE_DATA(MEM_WRITE_DATA), .MEM_READ_DATA(MEM_READ_DATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  // ---------------- memory: busy from request until latency elapsed ----------------
  int          lat = 1;
  int          mem_cnt = 0;
  int          cyc = 0;
  logic        mem_req;
  logic [31:0] wr_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0051_0113 : (a ^ 32'h5A5A_0000);
  endfunction

  assign mem_req       = (MEM_READ != 4'd0) || (MEM_WRITE != 3'd0);
  assign MEM_BUSYWAIT  = mem_req && (mem_cnt < lat);
  assign MEM_READ_DATA = (mem_req && !MEM_BUSYWAIT && MEM_READ != 4'd0) ? word_at(MEM_ADDR) : 32'd0;

  always @(posedge CLK) begin
    mem_cnt <= mem_req ? mem_cnt + 1 : 0;
    cyc     <= cyc + 1;
    if (mem_req && !MEM_BUSYWAIT && MEM_WRITE != 3'd0) begin
      wr_addr <= MEM_ADDR;
      wr_data <= MEM_WRITE_DATA;
    end
  end

  // ---------------- model: who owns the memory port ----------------
  int   m_owner = 0;   // 0 nobody, 1 fetch, 2 data
  int   m_dwins = 0;   // data wins while fetch waited, since the last fetch win
  logic m_dreq;
  logic m_pick_i;
`ifdef ARB_ROUND_ROBIN_EN
  logic m_last_i = 1'b1;
`endif

  assign m_dreq = (D_READ != 4'd0) || (D_WRITE != 3'd0);

  always_comb begin
    m_pick_i = I_READ;
    if (I_READ && m_dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
      m_pick_i = !m_last_i;
`else
      m_pick_i = (m_dwins >= STARVE);
`endif
    end
  end

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_owner <= 0;
      m_dwins <= 0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last_i <= 1'b1;
`endif
    end else if (m_owner != 0) begin
      if (!MEM_BUSYWAIT) m_owner <= 0;
    end else if (m_pick_i) begin
      m_owner <= 1;
      m_dwins <= 0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last_i <= 1'b1;
`endif
    end else if (m_dreq) begin
      m_owner <= 2;
      if (I_READ) m_dwins <= (m_dwins < 7) ? m_dwins + 1 : 7;
`ifdef ARB_ROUND_ROBIN_EN
      m_last_i <= 1'b0;
`endif
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int passed = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
  endtask

  // ---------------- per-cycle compare and bus monitor ----------------
  string       glog = "";
  int          gcyc[$];
  logic        prev_act = 1'b0;
  logic        i_done_now = 1'b0;
  logic        d_done_now = 1'b0;
  int          i_done_tot = 0;
  logic [31:0] cap_instr, cap_iaddr, cap_daddr, cap_dwd, cap_drdata;
  logic [3:0]  cap_iread;
  logic [2:0]  cap_dwrite;

  initial begin
    logic [136:0] act, exp;
    logic [3:0]   e_rd;
    logic [2:0]   e_wr;
    logic [31:0]  e_addr, e_wd, e_instr, e_drd;
    logic         e_ibw, e_dbw;
    forever begin
      @(negedge CLK);
      e_rd    = (m_owner == 1) ? I_CODE : ((m_owner == 2) ? D_READ : 4'd0);
      e_wr    = (m_owner == 2) ? D_WRITE : 3'd0;
      e_addr  = (m_owner == 1) ? I_ADDR : ((m_owner == 2) ? D_ADDR : 32'd0);
      e_wd    = (m_owner == 2) ? D_WRITE_DATA : 32'd0;
      e_instr = (m_owner == 1) ? MEM_READ_DATA : 32'd0;
      e_drd   = (m_owner == 2) ? MEM_READ_DATA : 32'd0;
      e_ibw   = I_READ && !(m_owner == 1 && !MEM_BUSYWAIT);
      e_dbw   = m_dreq && !(m_owner == 2 && !MEM_BUSYWAIT);
      exp = {e_rd, e_wr, e_addr, e_wd, e_instr, e_ibw, e_drd, e_dbw};
      act = {MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA, I_INSTRUCTION, I_BUSYWAIT,
             D_READ_DATA, D_BUSYWAIT};
      checks++;
      if (act === exp) passed++;
      else $display("FAIL cycle%0d outputs: got %h, expected %h", cyc, act, exp);

      if (mem_req && !prev_act) begin
        if (MEM_READ == I_CODE && MEM_WRITE == 3'd0) glog = {glog, "I"};
        else glog = {glog, "D"};
        gcyc.push_back(cyc);
      end
      prev_act   = mem_req;
      i_done_now = I_READ && !I_BUSYWAIT;
      d_done_now = m_dreq && !D_BUSYWAIT;
      if (i_done_now) begin
        i_done_tot++;
        cap_instr = I_INSTRUCTION;
        cap_iaddr = MEM_ADDR;
        cap_iread = MEM_READ;
      end
      if (d_done_now) begin
        cap_dwrite = MEM_WRITE;
        cap_daddr  = MEM_ADDR;
        cap_dwd    = MEM_WRITE_DATA;
        cap_drdata = D_READ_DATA;
      end
    end
  end

  // ---------------- requesters ----------------
  int         i_left = 0;
  int         d_left = 0;
  logic [3:0] d_rcode = 4'd0;
  logic [2:0] d_wcode = 3'd0;

  task automatic drive_req();
    I_READ  = (i_left > 0);
    D_READ  = (d_left > 0) ? d_rcode : 4'd0;
    D_WRITE = (d_left > 0) ? d_wcode : 3'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_log();
    glog = "";
    gcyc.delete();
    i_done_tot = 0;
  endtask

  // Each requester holds its fields until released at an edge, then moves on.
  task automatic run(input int budget, input string name);
    int n = 0;
    while ((i_left > 0 || d_left > 0) && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
      if (i_done_now) begin
        i_left--;
        I_ADDR = I_ADDR + 32'd4;
      end
      if (d_done_now) begin
        d_left--;
        D_ADDR       = D_ADDR + 32'd4;
        D_WRITE_DATA = D_WRITE_DATA + 32'd1;
      end
      drive_req();
    end
    chk32({name, "_done_in_budget"}, 32'(i_left == 0 && d_left == 0), 32'd1);
    i_left = 0;
    d_left = 0;
    drive_req();
  endtask

  function automatic int gap(input int k);
    return (gcyc.size() > k + 1) ? gcyc[k+1] - gcyc[k] : -1;
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    RESET = 1'b1;
    I_ADDR = 32'd0; I_READ = 1'b0;
    D_READ = 4'd0; D_WRITE = 3'd0; D_ADDR = 32'd0; D_WRITE_DATA = 32'd0;
    #1 RESET = 1'b0;
    I_READ = 1'b1;
    #2;
    chk32("rst_mem_read", 32'(MEM_READ), 32'd0);
    chk32("rst_mem_addr", MEM_ADDR, 32'd0);
    chk32("rst_mem_wdata", MEM_WRITE_DATA ^ 32'(MEM_WRITE), 32'd0);
    chk32("rst_ibusy_follows_req", 32'(I_BUSYWAIT), 32'd1);
    chk32("rst_dbusy", 32'(D_BUSYWAIT), 32'd0);
    chk32("rst_rdata", I_INSTRUCTION | D_READ_DATA, 32'd0);
    I_READ = 1'b0;
    idle(2);
    RESET = 1'b1;
    idle(2);

    // single fetch, two busy cycles
    clear_log();
    lat = 2; I_ADDR = 32'h40; i_left = 1; drive_req();
    run(100, "t1");
    chk32("t1_mem_read", 32'(cap_iread), 32'(I_CODE));
    chk32("t1_mem_addr", cap_iaddr, 32'h40);
    chk32("t1_instr", cap_instr, 32'h0051_0113);
    chk_str("t1_grants", glog, "I");
    idle(2);

    // single store
    clear_log();
    lat = 1; D_ADDR = 32'h100; D_WRITE_DATA = 32'hDEAD_BEEF;
    d_rcode = 4'd0; d_wcode = 3'b011; d_left = 1; drive_req();
    run(100, "t2");
    chk32("t2_mem_write", 32'(cap_dwrite), 32'd3);
    chk32("t2_mem_addr", cap_daddr, 32'h100);
    chk32("t2_mem_wdata", cap_dwd, 32'hDEAD_BEEF);
    chk32("t2_stored", wr_data, 32'hDEAD_BEEF);
    chk32("t2_stored_addr", wr_addr, 32'h100);
    idle(2);

    // contention: data first, IDLE bubble, then fetch
    clear_log();
    I_ADDR = 32'h80; D_ADDR = 32'h180; d_rcode = 4'b0100; d_wcode = 3'd0;
    i_left = 1; d_left = 1; drive_req();
    run(100, "t3");
    chk_str("t3_grants", glog, "DI");
    chk32("t3_gap", 32'(gap(0)), 32'd3);
    chk32("t3_instr", cap_instr, 32'h5A5A_0080);
    idle(2);

    // starvation guard / alternation, fetch held, data back-to-back
    clear_log();
    I_ADDR = 32'h2000; D_ADDR = 32'h3000; i_left = 3; d_left = 5; drive_req();
    run(300, "t4");
`ifdef ARB_ROUND_ROBIN_EN
    chk_str("t4_grants", glog, "DIDIDIDD");
`else
    chk_str("t4_grants", glog, "DDDDIDII");
`endif
    idle(2);

    // reset in the middle of a data access
    clear_log();
    lat = 6; D_ADDR = 32'h200; d_left = 1; drive_req();
    n = 0;
    while (MEM_READ == 4'd0 && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk32("t5_granted", 32'(MEM_READ), 32'h4);
    idle(1);
    RESET = 1'b0;
    #1;
    chk32("t5_mem_zero", 32'(MEM_READ) | MEM_ADDR | 32'(MEM_WRITE), 32'd0);
    chk32("t5_dbusy_held", 32'(D_BUSYWAIT), 32'd1);
    idle(2);
    lat = 1;
    RESET = 1'b1;
    run(100, "t5");
    chk_str("t5_grants", glog, "DD");
    chk32("t5_rdata", cap_drdata, 32'h5A5A_0200);
    idle(2);

    // back-to-back fetches, one-cycle memory
    clear_log();
    I_ADDR = 32'h1000; i_left = 4; drive_req();
    run(100, "t6");
    chk_str("t6_grants", glog, "IIII");
    for (int k = 0; k < 3; k++) chk32("t6_gap", 32'(gap(k)), 32'd3);
    chk32("t6_fetch_count", 32'(i_done_tot), 32'd4);
    chk32("t6_last_instr", cap_instr, 32'h5A5A_100C);
    idle(3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
